// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the dff_pipe elastic register pipeline.
// Optional parity storage is selected with the DFF_PIPE_PARITY_EN macro.
package dff_pipe_pkg;

  // Widest data beat the parity helper accepts; narrower beats are zero-extended.
  localparam int PAR_MAX_W = 256;

`ifdef DFF_PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of one stored stage: data plus the optional parity bit.
  function automatic int stage_width(input int width);
    return width + PAR_W;
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready bus of dff_pipe: upstream beat, downstream beat, flush and status.
// parity_err_o exists only when DFF_PIPE_PARITY_EN is defined.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import dff_pipe_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] d_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] q_o;
  logic [CNT_W-1:0] count_o;
`ifdef DFF_PIPE_PARITY_EN
  logic             parity_err_o;

  modport master (
    output flush_i, valid_i, d_i, ready_i,
    input  ready_o, valid_o, q_o, count_o, parity_err_o
  );
  modport slave (
    input  flush_i, valid_i, d_i, ready_i,
    output ready_o, valid_o, q_o, count_o, parity_err_o
  );
`else
  modport master (
    output flush_i, valid_i, d_i, ready_i,
    input  ready_o, valid_o, q_o, count_o
  );
  modport slave (
    input  flush_i, valid_i, d_i, ready_i,
    output ready_o, valid_o, q_o, count_o
  );
`endif

endinterface

// File: rtl/dff_pipe_stage.sv
// One elastic register stage: holds a beat until the next stage can take it.
module dff_pipe_stage #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         in_ready
);

  logic         vld_r;
  logic [W-1:0] dat_r;

  // Empty stages, or stages whose beat leaves this edge, can take a new one.
  assign in_ready  = !vld_r || out_ready;
  assign out_valid = vld_r;
  assign out_data  = dat_r;

  // Valid/data register; flush drops the beat but leaves the data bits alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_r <= 1'b0;
      dat_r <= RESET_VAL;
    end else if (flush_i) begin
      vld_r <= 1'b0;
    end else if (in_ready) begin
      vld_r <= in_valid;
      if (in_valid) begin
        dat_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Top of the elastic register pipeline: DEPTH chained stages, occupancy count
// and, with DFF_PIPE_PARITY_EN defined, a sticky output parity check.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dff_pipe_if.slave  bus
);

  localparam int STAGE_W = stage_width(WIDTH);
  localparam int CNT_W   = cnt_width(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
  localparam logic [STAGE_W-1:0] STAGE_RST = {calc_parity(PAR_MAX_W'(RESET_VAL)), RESET_VAL};
`else
  localparam logic [STAGE_W-1:0] STAGE_RST = RESET_VAL;
`endif

  logic [DEPTH-1:0]   vld_s;
  logic [DEPTH-1:0]   rdy_s;
  logic [STAGE_W-1:0] dat_s [DEPTH];
  logic [STAGE_W-1:0] head_s;
  logic               in_fire_s;
  logic               out_fire_s;
  logic [CNT_W-1:0]   count_r;

`ifdef DFF_PIPE_PARITY_EN
  assign head_s = {calc_parity(PAR_MAX_W'(bus.d_i)), bus.d_i};
`else
  assign head_s = bus.d_i;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic               in_valid_s;
    logic [STAGE_W-1:0] in_data_s;
    logic               out_ready_s;

    if (k == 0) begin : g_head
      assign in_valid_s = bus.valid_i;
      assign in_data_s  = head_s;
    end else begin : g_body
      assign in_valid_s = vld_s[k-1];
      assign in_data_s  = dat_s[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign out_ready_s = bus.ready_i;
    end else begin : g_mid
      assign out_ready_s = rdy_s[k+1];
    end

    dff_pipe_stage #(
      .W         (STAGE_W),
      .RESET_VAL (STAGE_RST)
    ) u_stage (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (bus.flush_i),
      .in_valid  (in_valid_s),
      .in_data   (in_data_s),
      .out_ready (out_ready_s),
      .out_valid (vld_s[k]),
      .out_data  (dat_s[k]),
      .in_ready  (rdy_s[k])
    );
  end

  assign bus.ready_o = rdy_s[0] && !bus.flush_i;
  assign bus.valid_o = vld_s[DEPTH-1];
  assign bus.q_o     = dat_s[DEPTH-1][WIDTH-1:0];
  assign bus.count_o = count_r;

  assign in_fire_s  = bus.valid_i && bus.ready_o;
  assign out_fire_s = bus.valid_o && bus.ready_i;

  // Occupancy tracks accepts minus drains, so it always equals popcount(vld) after the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= {CNT_W{1'b0}};
    end else if (bus.flush_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (in_fire_s && !out_fire_s) begin
      count_r <= count_r + CNT_W'(1);
    end else if (!in_fire_s && out_fire_s) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic parity_err_r;

  assign bus.parity_err_o = parity_err_r;

  // Sticky error, checked only on beats actually handed downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_r <= 1'b0;
    end else if (bus.flush_i) begin
      parity_err_r <= 1'b0;
    end else if (out_fire_s &&
                 (calc_parity(PAR_MAX_W'(bus.q_o)) != dat_s[DEPTH-1][STAGE_W-1])) begin
      parity_err_r <= 1'b1;
    end else begin
      parity_err_r <= parity_err_r;
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5):
// vector table plus scoreboard-checked sequences.
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam int              WIDTH = 8;
  localparam int              DEPTH = 4;
  localparam logic [WIDTH-1:0] RV   = 8'hA5;
  localparam int              CNT_W = cnt_width(DEPTH);

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       exp_rdy;
    logic       exp_vld;
    logic [7:0] exp_q;
    int         exp_cnt;
  } vec_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic       s_ready;
  logic       s_valid;
  logic [7:0] s_q;
  logic [CNT_W-1:0] s_cnt;
  vec_t       tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, sample before the next rising edge, update the scoreboard.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic [7:0] exp_d;
    @(negedge clk_i);
    bus.valid_i = v;
    bus.d_i     = d;
    bus.ready_i = r;
    bus.flush_i = f;
    #1;
    s_ready = bus.ready_o;
    s_valid = bus.valid_o;
    s_q     = bus.q_o;
    s_cnt   = bus.count_o;
    check("count_vs_model", 32'(s_cnt), 32'(sb_q.size()));
    if (f) begin
      check("ready_during_flush", 32'(s_ready), 32'd0);
      sb_q.delete();
    end else begin
      if (r && sb_q.size() == 0) begin
        check("no_beat_expected", 32'(s_valid), 32'd0);
      end else if (r && s_valid) begin
        exp_d = sb_q.pop_front();
        check("beat_data", 32'(s_q), 32'(exp_d));
      end
      if (v && s_ready) begin
        sb_q.push_back(d);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'hA5, 2};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'hA5, 3};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 4};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 4};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h11, 4};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 4};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 3};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55, 0};

    bus.valid_i = 1'b0;
    bus.d_i     = 8'h00;
    bus.ready_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_q_o", 32'(bus.q_o), 32'(RV));
    check("rst_count_o", 32'(bus.count_o), 32'd0);
    check("rst_ready_o", 32'(bus.ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill, stall, full pass-through, drain with stalls.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      check($sformatf("tbl%0d_ready_o", i), 32'(s_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_valid_o", i), 32'(s_valid), 32'(tbl[i].exp_vld));
      check($sformatf("tbl%0d_q_o", i), 32'(s_q), 32'(tbl[i].exp_q));
      check($sformatf("tbl%0d_count_o", i), 32'(s_cnt), 32'(tbl[i].exp_cnt));
    end

    // Back-to-back streaming: first beat visible after the fourth edge.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
      check("stream_ready_o", 32'(s_ready), 32'd1);
      if (i == 3) check("stream_latency_early", 32'(s_valid), 32'd0);
      if (i == 4) check("stream_first_beat", 32'({s_valid, s_q}), 32'({1'b1, 8'h01}));
      if (i == 8) check("stream_steady_count", 32'(s_cnt), 32'd4);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_drained", 32'(sb_q.size()), 32'd0);

    // Flush with two beats in flight and a beat offered in the flush cycle.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_valid_o", 32'(s_valid), 32'd0);
    check("flush_count_o", 32'(s_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("flush_no_output", 32'(s_valid), 32'd0);
    end

    // Bubbles collapse behind a stalled output.
    cycle(1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("bubble_count", 32'(s_cnt), 32'd2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("bubble_adjacent", 32'({s_valid, s_q}), 32'({1'b1, 8'h72}));

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 20 && (sb_q.size() != 0 || bus.valid_o); i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("random_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset with three beats in flight.
    cycle(1'b1, 8'h61, 1'b0, 1'b0);
    cycle(1'b1, 8'h62, 1'b0, 1'b0);
    cycle(1'b1, 8'h63, 1'b0, 1'b0);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
    check("midrst_q_o", 32'(bus.q_o), 32'(RV));
    check("midrst_count_o", 32'(bus.count_o), 32'd0);
    check("midrst_ready_o", 32'(bus.ready_o), 32'd1);
    sb_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("postrst_ready_o", 32'(bus.ready_o), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt the output stage so its stored parity no longer matches.
    cycle(1'b1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("par_clean", 32'(bus.parity_err_o), 32'd0);
    @(negedge clk_i);
    force dut.g_stage[DEPTH-1].u_stage.dat_r = 9'h00E;
    bus.ready_i = 1'b1;
    @(negedge clk_i);
    release dut.g_stage[DEPTH-1].u_stage.dat_r;
    sb_q.delete();
    #1;
    check("par_err_set", 32'(bus.parity_err_o), 32'd1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("par_err_sticky", 32'(bus.parity_err_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("par_err_flushed", 32'(bus.parity_err_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
